// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch/prefetch unit.
//   fetch_state_e : fetch FSM encoding (boot, run, drain of in-flight responses)
//   Default*      : default address/instruction widths and sequential PC step
//   slot_width()  : packed width of one prefetch slot {pc, instr, filled}
package fetch_pkg;

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

  localparam int unsigned DefaultXlen  = 32;
  localparam int unsigned DefaultIlen  = 32;
  localparam int unsigned DefaultPcInc = 4;

  function automatic int unsigned slot_width(input int unsigned xlen, input int unsigned ilen);
    return xlen + ilen + 1;
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue.sv
// In-order prefetch queue. A slot is allocated (pc known, instr pending) when a request is
// granted, filled when its response returns, and popped from the head by decode.
// Ports:
//   i_clk, i_rst_n      : clock, synchronous active-low reset
//   i_flush             : drop every slot (redirect); overrides alloc/fill/pop
//   i_alloc, i_alloc_pc : allocate tail slot with the granted fetch address
//   i_fill, i_fill_instr: write the oldest unfilled slot with returned instruction
//   i_pop               : retire the head slot
//   o_head_*            : head slot contents; valid only once filled
//   o_used_slots        : allocated slots (filled or not)
//   o_unfilled          : allocated slots still waiting for a response
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN  = DefaultXlen,
  parameter int unsigned ILEN  = DefaultIlen,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_alloc,
  input  logic [XLEN-1:0]            i_alloc_pc,
  input  logic                       i_fill,
  input  logic [ILEN-1:0]            i_fill_instr,
  input  logic                       i_pop,
  output logic                       o_head_valid,
  output logic [XLEN-1:0]            o_head_pc,
  output logic [ILEN-1:0]            o_head_instr,
  output logic [$clog2(DEPTH):0]     o_used_slots,
  output logic [$clog2(DEPTH):0]     o_unfilled
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = slot_width(XLEN, ILEN);

  // Slot layout: [SW-1:ILEN+1] pc, [ILEN:1] instr, [0] filled
  logic [SW-1:0] r_slot [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [CW-1:0] r_alloc_ptr;
  logic [CW-1:0] r_fill_ptr;
  logic [CW-1:0] r_head_ptr;

  logic [AW-1:0] w_alloc_idx;
  logic [AW-1:0] w_fill_idx;
  logic [AW-1:0] w_head_idx;
  logic [SW-1:0] w_head_slot;

  assign w_alloc_idx = r_alloc_ptr[AW-1:0];
  assign w_fill_idx  = r_fill_ptr[AW-1:0];
  assign w_head_idx  = r_head_ptr[AW-1:0];
  assign w_head_slot = r_slot[w_head_idx];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_slot[i] <= '0;
      end
    end else if (i_flush) begin
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_slot[i][0] <= 1'b0;
      end
    end else begin
      // alloc, fill and pop never target the same slot: alloc needs a non-full queue,
      // fill needs an unfilled slot, pop needs a filled head
      if (i_alloc) begin
        r_slot[w_alloc_idx][SW-1:ILEN+1] <= i_alloc_pc;
        r_slot[w_alloc_idx][0]           <= 1'b0;
        r_alloc_ptr                      <= r_alloc_ptr + CW'(1);
      end
      if (i_fill) begin
        r_slot[w_fill_idx][ILEN:1] <= i_fill_instr;
        r_slot[w_fill_idx][0]      <= 1'b1;
        r_fill_ptr                 <= r_fill_ptr + CW'(1);
      end
      if (i_pop) begin
        // Clear the flag so a wrapped, not yet refilled slot never looks valid
        r_slot[w_head_idx][0] <= 1'b0;
        r_head_ptr            <= r_head_ptr + CW'(1);
      end
    end
  end

  assign o_head_valid = w_head_slot[0];
  assign o_head_instr = w_head_slot[ILEN:1];
  assign o_head_pc    = w_head_slot[SW-1:ILEN+1];
  assign o_used_slots = r_alloc_ptr - r_head_ptr;
  assign o_unfilled   = r_alloc_ptr - r_fill_ptr;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage with prefetch queue. Issues sequential fetches under req/gnt, buffers in-order
// responses with their PCs, and hands them to decode under valid/stall. A redirect flushes
// the queue and counts every still-outstanding response so it can be discarded on return.
// Ports:
//   inp_clk, inp_rst_n            : clock, synchronous active-low reset
//   inp_pcsrc, inp_branchTarget   : redirect request and target PC
//   inp_stall                     : decode not accepting this cycle
//   out_imem_req, out_imem_addr   : fetch request and address (held until granted)
//   inp_imem_gnt                  : memory accepted the request
//   inp_imem_rvalid/rdata         : in-order response
//   out_valid, out_instr, out_pc  : instruction presented to decode
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN      = DefaultXlen,
  parameter int unsigned     ILEN      = DefaultIlen,
  parameter int unsigned     BUF_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     PC_INC    = DefaultPcInc
) (
  input  logic            inp_clk,
  input  logic            inp_rst_n,
  input  logic            inp_pcsrc,
  input  logic [XLEN-1:0] inp_branchTarget,
  input  logic            inp_stall,
  output logic            out_imem_req,
  output logic [XLEN-1:0] out_imem_addr,
  input  logic            inp_imem_gnt,
  input  logic            inp_imem_rvalid,
  input  logic [ILEN-1:0] inp_imem_rdata,
  output logic            out_valid,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam int unsigned CW   = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned SumW = CW + 1;

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_drop_cnt;

  logic [CW-1:0]   w_used;
  logic [CW-1:0]   w_unfilled;
  logic [CW-1:0]   w_drop_d;
  logic            w_room;
  logic            w_grant;
  logic            w_fill;
  logic            w_pop;
  logic            w_head_valid;

  // Outstanding responses (kept or to be dropped) must never exceed the slot count
  assign w_room  = (SumW'(w_used) + SumW'(r_drop_cnt)) < SumW'(BUF_DEPTH);
  assign out_imem_req  = (r_state != StBoot) && w_room;
  assign out_imem_addr = r_fetch_pc;

  assign w_grant = out_imem_req && inp_imem_gnt;
  assign w_fill  = inp_imem_rvalid && (r_drop_cnt == '0);
  assign w_pop   = w_head_valid && !inp_stall && !inp_pcsrc;

  always_comb begin
    w_drop_d = r_drop_cnt;
    if (inp_pcsrc) begin
      // A same-cycle response retires either one pending drop or one unfilled slot, so it
      // always removes exactly one from the outstanding total
      w_drop_d = r_drop_cnt + w_unfilled + CW'(w_grant) - CW'(inp_imem_rvalid);
    end else if (inp_imem_rvalid && (r_drop_cnt != '0)) begin
      w_drop_d = r_drop_cnt - CW'(1);
    end
  end

  always_ff @(posedge inp_clk) begin
    if (!inp_rst_n) begin
      r_state    <= StBoot;
      r_fetch_pc <= RESET_PC;
      r_drop_cnt <= '0;
    end else begin
      r_drop_cnt <= w_drop_d;
      if (inp_pcsrc) begin
        r_fetch_pc <= inp_branchTarget;
      end else if (w_grant) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(PC_INC);
      end
      case (r_state)
        StBoot:  r_state <= StRun;
        StRun: begin
          if (inp_pcsrc && ((w_unfilled != '0) || w_grant)) begin
            r_state <= StDrain;
          end
        end
        StDrain: begin
          if (!inp_pcsrc && (w_drop_d == '0)) begin
            r_state <= StRun;
          end
        end
        default: r_state <= StBoot;
      endcase
    end
  end

  fetch_prefetch_queue #(
    .XLEN  (XLEN),
    .ILEN  (ILEN),
    .DEPTH (BUF_DEPTH)
  ) u_queue (
    .i_clk        (inp_clk),
    .i_rst_n      (inp_rst_n),
    .i_flush      (inp_pcsrc),
    .i_alloc      (w_grant),
    .i_alloc_pc   (r_fetch_pc),
    .i_fill       (w_fill),
    .i_fill_instr (inp_imem_rdata),
    .i_pop        (w_pop),
    .o_head_valid (w_head_valid),
    .o_head_pc    (out_pc),
    .o_head_instr (out_instr),
    .o_used_slots (w_used),
    .o_unfilled   (w_unfilled)
  );

  assign out_valid = w_head_valid;

  // A response with nothing waiting for it and nothing to drop is a memory protocol error
  a_rvalid_expected : assert property (@(posedge inp_clk) disable iff (!inp_rst_n)
    inp_imem_rvalid |-> ((r_drop_cnt != '0) || (w_unfilled != '0)));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: a response-latency memory model, a scoreboard of expected
// {pc, instr} pairs, a cycle table for start-up, and hand sequences for stall, redirect and
// reset corner cases. A second instance with RESET_PC near the top of the address space
// shares all inputs and is used to check address wrap-around.
module tb_fetch_prefetch_unit;

  typedef struct {
    logic [31:0] addr;
    int          gcyc;
  } mem_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic        gnt;
    logic        stall;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr_wrap;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        pcsrc;
  logic [31:0] target;
  logic        stall;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;

  mem_t mem_q[$];
  exp_t exp_q[$];
  vec_t tbl[7];

  int n_chk;
  int n_err;
  int cyc;
  int gnt_cnt;
  int resp_lat;
  bit resp_en;

  fetch_prefetch_unit #(
    .BUF_DEPTH (4),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .inp_clk          (clk),
    .inp_rst_n        (rst_n),
    .inp_pcsrc        (pcsrc),
    .inp_branchTarget (target),
    .inp_stall        (stall),
    .out_imem_req     (imem_req),
    .out_imem_addr    (imem_addr),
    .inp_imem_gnt     (gnt),
    .inp_imem_rvalid  (rvalid),
    .inp_imem_rdata   (rdata),
    .out_valid        (out_valid),
    .out_instr        (out_instr),
    .out_pc           (out_pc)
  );

  fetch_prefetch_unit #(
    .BUF_DEPTH (4),
    .RESET_PC  (32'hFFFF_FFF8)
  ) dut_wrap (
    .inp_clk          (clk),
    .inp_rst_n        (rst_n),
    .inp_pcsrc        (pcsrc),
    .inp_branchTarget (target),
    .inp_stall        (stall),
    .out_imem_req     (w_req),
    .out_imem_addr    (w_addr),
    .inp_imem_gnt     (gnt),
    .inp_imem_rvalid  (rvalid),
    .inp_imem_rdata   (rdata),
    .out_valid        (w_valid),
    .out_instr        (w_instr),
    .out_pc           (w_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: answer the oldest granted request once its latency has elapsed
  task automatic drive_mem();
    if (resp_en && mem_q.size() > 0 && (mem_q[0].gcyc + resp_lat <= cyc)) begin
      rvalid = 1'b1;
      rdata  = instr_of(mem_q[0].addr);
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
    end
  endtask

  // Sample away from the edge and update the memory model and scoreboard
  task automatic obs();
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (out_valid && !stall && !pcsrc) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL sb_unexpected: got pc %h, required no delivery (cycle %0d)", out_pc, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", out_pc, e.pc);
          chk("sb_instr", out_instr, e.instr);
        end
      end
      if (pcsrc) exp_q.delete();
      if (rvalid) mem_q.delete(0);
      if (imem_req && gnt) begin
        mem_q.push_back('{addr: imem_addr, gcyc: cyc});
        if (!pcsrc) exp_q.push_back('{pc: imem_addr, instr: instr_of(imem_addr)});
        gnt_cnt++;
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
    drive_mem();
  endtask

  task automatic cycle();
    obs();
    adv();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    pcsrc   = 1'b0;
    target  = '0;
    stall   = 1'b0;
    gnt     = 1'b0;
    resp_en = 1'b0;
    mem_q.delete();
    exp_q.delete();
    rvalid  = 1'b0;
    rdata   = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_0000);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    cyc      = 0;
    gnt_cnt  = 0;
    resp_en  = 1'b1;
    resp_lat = 1;
    drive_mem();
  endtask

  initial begin
    bit found;
    n_chk    = 0;
    n_err    = 0;
    cyc      = 0;
    gnt_cnt  = 0;
    resp_lat = 1;
    resp_en  = 1'b0;
    rst_n    = 1'b0;
    pcsrc    = 1'b0;
    target   = '0;
    stall    = 1'b0;
    gnt      = 1'b0;
    rvalid   = 1'b0;
    rdata    = '0;

    //           gnt   stall req   addr   valid pc     wrap-instance addr
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 32'd0,  32'hFFFF_FFF8};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 32'd0,  1'b0, 32'd0,  32'hFFFF_FFF8};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 32'd4,  1'b0, 32'd0,  32'hFFFF_FFFC};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 32'd8,  1'b1, 32'd0,  32'h0000_0000};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 32'd12, 1'b1, 32'd4,  32'h0000_0004};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 32'd16, 1'b1, 32'd8,  32'h0000_0008};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 32'd20, 1'b1, 32'd12, 32'h0000_000C};

    // Start-up and streaming, one row per cycle after reset release
    do_reset();
    for (int i = 0; i < 7; i++) begin
      gnt   = tbl[i].gnt;
      stall = tbl[i].stall;
      obs();
      chk("tbl_req", {31'b0, imem_req}, {31'b0, tbl[i].exp_req});
      chk("tbl_addr", imem_addr, tbl[i].exp_addr);
      chk("tbl_valid", {31'b0, out_valid}, {31'b0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) begin
        chk("tbl_pc", out_pc, tbl[i].exp_pc);
        chk("tbl_instr", out_instr, instr_of(tbl[i].exp_pc));
      end
      chk("tbl_wrap_addr", w_addr, tbl[i].exp_addr_wrap);
      adv();
    end

    // Stall held: queue fills after exactly four grants, then drains in order
    do_reset();
    gnt   = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 14; i++) cycle();
    obs();
    chk("stall_grants", gnt_cnt, 32'd4);
    chk("stall_req_off", {31'b0, imem_req}, 32'd0);
    chk("stall_addr_hold", imem_addr, 32'd16);
    adv();
    stall = 1'b0;
    obs();
    chk("stall_pop0", out_pc, 32'd0);
    chk("stall_full_req", {31'b0, imem_req}, 32'd0);
    adv();
    obs();
    chk("stall_pop1", out_pc, 32'd4);
    chk("stall_resume_req", {31'b0, imem_req}, 32'd1);
    chk("stall_resume_addr", imem_addr, 32'd16);
    adv();
    obs();
    chk("stall_pop2", out_pc, 32'd8);
    adv();
    obs();
    chk("stall_pop3", out_pc, 32'd12);
    adv();
    for (int i = 0; i < 4; i++) cycle();

    // Redirect with two responses still in flight
    do_reset();
    resp_en = 1'b0;
    gnt     = 1'b1;
    cycle();
    cycle();
    cycle();
    gnt    = 1'b0;
    pcsrc  = 1'b1;
    target = 32'h0000_0100;
    obs();
    chk("redir_inflight", mem_q.size(), 32'd2);
    adv();
    pcsrc    = 1'b0;
    gnt      = 1'b1;
    resp_en  = 1'b1;
    drive_mem();
    obs();
    chk("redir_addr", imem_addr, 32'h0000_0100);
    chk("redir_req", {31'b0, imem_req}, 32'd1);
    chk("redir_valid", {31'b0, out_valid}, 32'd0);
    adv();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      obs();
      if (out_valid) begin
        found = 1'b1;
        chk("redir_first_pc", out_pc, 32'h0000_0100);
      end
      adv();
    end
    if (!found) chk("redir_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 6; i++) cycle();

    // Redirect coinciding with grant, response and pop
    do_reset();
    gnt = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    pcsrc  = 1'b1;
    target = 32'h0000_0200;
    obs();
    chk("coinc_pre_valid", {31'b0, out_valid}, 32'd1);
    chk("coinc_pre_grant", {31'b0, imem_req & rvalid}, 32'd1);
    adv();
    pcsrc = 1'b0;
    obs();
    chk("coinc_valid", {31'b0, out_valid}, 32'd0);
    chk("coinc_addr", imem_addr, 32'h0000_0200);
    chk("coinc_req", {31'b0, imem_req}, 32'd1);
    adv();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      obs();
      if (out_valid) begin
        found = 1'b1;
        chk("coinc_first_pc", out_pc, 32'h0000_0200);
      end
      adv();
    end
    if (!found) chk("coinc_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 6; i++) cycle();

    // Grant withheld: request and address hold; then reset in the middle of a burst
    do_reset();
    gnt = 1'b0;
    cycle();
    for (int i = 0; i < 5; i++) begin
      obs();
      chk("nognt_req", {31'b0, imem_req}, 32'd1);
      chk("nognt_addr", imem_addr, 32'd0);
      adv();
    end
    gnt = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Parametrised successor of the pipeline fetch stage.
- Generates sequential PCs and issues requests to instruction memory under a req/gnt handshake.
- Buffers returned instructions with their PCs in an in-order prefetch queue of BUF_DEPTH slots, and presents them to decode under a valid/stall handshake.
- On a redirect (inp_pcsrc) it flushes the queue, discards in-flight responses and restarts fetch at inp_branchTarget.

Parameters:
- XLEN, 32, PC/address width.
- ILEN, 32, instruction width.
- BUF_DEPTH, 4, prefetch queue slots; power of 2, minimum 2.
- RESET_PC, 0, first fetch address after reset.
- PC_INC, 4, sequential PC increment.

Ports:
- inp_clk  in  1  clock; all logic updates on its rising edge.
- inp_rst_n  in  1  synchronous active-low reset.
- inp_pcsrc  in  1  redirect request (taken branch or jump).
- inp_branchTarget  in  XLEN  redirect target PC.
- inp_stall  in  1  decode cannot accept this cycle.
- out_imem_req  out  1  fetch request valid.
- out_imem_addr  out  XLEN  fetch address.
- inp_imem_gnt  in  1  memory accepts the request this cycle.
- inp_imem_rvalid  in  1  response valid; responses return in order, at least 1 cycle after grant.
- inp_imem_rdata  in  ILEN  response instruction.
- out_valid  out  1  out_instr/out_pc are valid.
- out_instr  out  ILEN  instruction to decode.
- out_pc  out  XLEN  PC of out_instr.

Behaviour:
- Reset (inp_rst_n=0 at an edge) gives:
  - state=BOOT, fetch_pc=RESET_PC, queue empty, drop_cnt=0.
  - out_imem_req=0, out_imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
  - Reset mid-operation discards everything, including outstanding requests. The bench must hold rvalid low until memory is idle.
- State machine:
  - BOOT -> RUN after one cycle.
  - RUN -> DRAIN on a redirect with unfilled slots, or with a grant in the same cycle.
  - DRAIN -> RUN when drop_cnt reaches 0.
  - DRAIN + redirect: stay in DRAIN, drop_cnt += unfilled slots (+1 if granted that cycle).
- Queue slot layout: {pc, instr, filled}.
  - Allocation: on each req&&gnt, slot at alloc_ptr gets pc=out_imem_addr and filled=0.
  - Fill: rvalid with drop_cnt=0 fills the slot at fill_ptr.
- Request issue:
  - out_imem_req=1 in RUN/DRAIN when used_slots + drop_cnt < BUF_DEPTH.
  - out_imem_addr=fetch_pc, held stable until gnt.
  - Exception: a redirect changes the address to the target the next cycle.
  - On req&&gnt: fetch_pc += PC_INC, truncated modulo 2^XLEN, so wrap-around is permitted.
- Response path:
  - rvalid with drop_cnt>0 is discarded and drop_cnt decrements.
  - rvalid with drop_cnt=0 fills a slot.
  - rvalid with no unfilled slot and drop_cnt=0 is a protocol error (assertion).
- Output:
  - out_valid=1 iff the head slot is filled; out_instr/out_pc come from the head slot.
  - Latency: a response filled in cycle N appears on out_valid in cycle N+1.
  - Head pops when out_valid && !inp_stall.
  - Minimum latency from reset release: req in cycle 1, gnt cycle 1, rvalid cycle 2, out_valid cycle 3.
- Redirect (inp_pcsrc=1) takes priority over every other event in the cycle:
  - Queue is cleared and out_valid=0 next cycle; a simultaneous pop is ignored.
  - drop_cnt += unfilled allocated slots + (req&&gnt this cycle).
  - A same-cycle rvalid is counted against the old drop/fill accounting first (dropped or discarded), never delivered.
  - fetch_pc=inp_branchTarget, and the request for it is issued from the next cycle.
- Full queue: no request issues. Pop and fill in the same cycle are both honoured.
- Stall: the queue holds; prefetch continues until full.
- Throughput: one instruction per cycle sustained when gnt=1 every cycle, response latency L<=BUF_DEPTH-1, and no stall.
- Counter widths: used_slots and drop_cnt are clog2(BUF_DEPTH)+1 bits.

Decomposition:
- Shared package fetch_pkg holds:
  - State encodings BOOT/RUN/DRAIN.
  - Default XLEN/ILEN/PC_INC constants.
  - The slot-struct width helper.
- One natural sub-module, fetch_prefetch_queue: alloc/fill/pop pointers, filled flags, flush, used_slots count.
- Top level holds the FSM, fetch_pc, drop_cnt and the issue logic.

Test Plan:
- Reset release, gnt=1 always, rvalid 1 cycle after gnt, no stall -> out_imem_addr 0,4,8,...; out_valid from cycle 3; out_pc 0,4,8 on consecutive cycles.
- inp_stall=1 held, BUF_DEPTH=4 -> exactly 4 grants then out_imem_req=0. Release stall -> pops of pc 0,4,8,12 on consecutive cycles, then issue resumes at 16.
- Redirect to 0x100 with 2 responses in flight -> DRAIN; the 2 responses are discarded; first out_pc=0x100, with no stale PCs delivered.
- Redirect in the same cycle as gnt, rvalid and pop -> queue empty next cycle; drop_cnt includes the grant; out_imem_addr=target next cycle.
- RESET_PC=0xFFFFFFF8 -> fetch addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0 (wrap).
- gnt withheld 5 cycles -> out_imem_req stays 1 with a stable address. Reset asserted mid-burst -> all outputs return to reset values the next cycle.
